dram_sweep_sequencer: RTL

Autonomous write/read-back sweep controller for the 16-core DRAM write/read datapath. Sits between the board-level debounced start pulse and `DRAM_write_read_16core`. For each word-line row it drives IO mode, addresses and write pattern, pulses IO_EN, and waits for WT_DONE/RD_DONE. It then compares the 16 readout bytes against the expected pattern and streams a 3-byte per-row report to `uart_send`.

---
 rtl/dram_ctrl_pkg.sv | 31 +++
 rtl/byte_mismatch16.sv | 19 +
 rtl/dram_sweep_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the DRAM sweep controller.
// State encoding, IO_MODEL codes, report length, row-byte helper.
package dram_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_SET,
    S_WR_PULSE,
    S_WR_WAIT,
    S_RD_SET,
    S_RD_PULSE,
    S_RD_WAIT,
    S_CHECK,
    S_TX,
    S_NEXT
  } state_e;

  localparam logic [1:0] WR_MODEL_D = 2'b01;
  localparam logic [1:0] RD_MODEL_D = 2'b10;

  localparam int         REPORT_BYTES = 3;
  localparam logic [1:0] TX_LAST = 2'(REPORT_BYTES - 1);

  function automatic logic [7:0] row_byte(
    input logic [7:0] seed,
    input logic [5:0] row
  );
    return seed ^ {2'b00, row};
  endfunction

endpackage

// File: rtl/byte_mismatch16.sv
// Compares 16 readout bytes against one expected byte.
// Ports: i_data (16 bytes), i_exp; o_mask (bit k = byte k differs), o_pop.
module byte_mismatch16 (
  input  logic [127:0] i_data,
  input  logic [7:0]   i_exp,
  output logic [15:0]  o_mask,
  output logic [4:0]   o_pop
);

  always_comb begin
    o_mask = '0;
    o_pop  = '0;
    for (int k = 0; k < 16; k++) begin
      o_mask[k] = (i_data[8*k +: 8] != i_exp);
      o_pop     = o_pop + {4'b0000, o_mask[k]};
    end
  end

endmodule

// File: rtl/dram_sweep_sequencer.sv
// Row-by-row write/read-back sweep over the 16-core DRAM datapath.
// Inputs: clk_100m, rst, start, abort, wt_done, rd_done, dram_data_out,
// tx_busy. Outputs: io_en, io_model, wwl_add, rwl_dec_add, wbl_pattern,
// tx_en, tx_data, busy, sweep_done, timeout_err, err_count.
module dram_sweep_sequencer
  import dram_ctrl_pkg::*;
#(
  parameter int         NUM_ROWS = 64,
  parameter logic [7:0] SEED     = 8'h55,
  parameter logic [1:0] WR_MODEL = WR_MODEL_D,
  parameter logic [1:0] RD_MODEL = RD_MODEL_D,
  parameter logic [19:0] TIMEOUT = 20'd1_000_000
) (
  input  logic         clk_100m,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         wt_done,
  input  logic         rd_done,
  input  logic [127:0] dram_data_out,
  input  logic         tx_busy,
  output logic         io_en,
  output logic [1:0]   io_model,
  output logic [5:0]   wwl_add,
  output logic [5:0]   rwl_dec_add,
  output logic [63:0]  wbl_pattern,
  output logic         tx_en,
  output logic [7:0]   tx_data,
  output logic         busy,
  output logic         sweep_done,
  output logic         timeout_err,
  output logic [15:0]  err_count
);

  localparam logic [5:0]  LAST_ROW = 6'(NUM_ROWS - 1);
  localparam logic [19:0] TMO_LAST = TIMEOUT - 20'd1;

  state_e        r_state;
  state_e        w_nxt;
  logic [5:0]    r_row;
  logic [19:0]   r_tmo;
  logic [1:0]    r_tx_idx;
  logic          r_wt_q;
  logic          r_rd_q;
  logic [15:0]   r_mask;
  logic          r_io_en;
  logic [1:0]    r_io_model;
  logic [5:0]    r_wwl;
  logic [5:0]    r_rwl;
  logic [63:0]   r_wbl;
  logic          r_tx_en;
  logic [7:0]    r_tx_data;
  logic          r_busy;
  logic          r_sweep_done;
  logic          r_timeout_err;
  logic [15:0]   r_err_count;

  logic [7:0]    w_pb;
  logic [15:0]   w_mask;
  logic [4:0]    w_pop;
  logic          w_wt_edge;
  logic          w_rd_edge;
  logic          w_tmo_hit;
  logic          w_tx_go;
  logic          w_last_row;
  logic [7:0]    w_tx_byte;
  logic [16:0]   w_sum;

  byte_mismatch16 u_cmp (
    .i_data (dram_data_out),
    .i_exp  (w_pb),
    .o_mask (w_mask),
    .o_pop  (w_pop)
  );

  assign w_pb       = row_byte(SEED, r_row);
  assign w_wt_edge  = wt_done & ~r_wt_q;
  assign w_rd_edge  = rd_done & ~r_rd_q;
  assign w_tmo_hit  = (r_tmo == TMO_LAST);
  // One strobe per byte; busy shows up a cycle after the strobe.
  assign w_tx_go    = ~tx_busy & ~r_tx_en;
  assign w_last_row = (r_row == LAST_ROW);
  assign w_sum      = {1'b0, r_err_count} + {12'd0, w_pop};

  always_comb begin
    w_tx_byte = r_mask[7:0];
    unique case (r_tx_idx)
      2'd0:    w_tx_byte = {2'b00, r_row};
      2'd1:    w_tx_byte = r_mask[15:8];
      default: w_tx_byte = r_mask[7:0];
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    if (abort) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:     if (start) w_nxt = S_WR_SET;
        S_WR_SET:   w_nxt = S_WR_PULSE;
        S_WR_PULSE: w_nxt = S_WR_WAIT;
        S_WR_WAIT: begin
          if (w_wt_edge)      w_nxt = S_RD_SET;
          else if (w_tmo_hit) w_nxt = S_IDLE;
        end
        S_RD_SET:   w_nxt = S_RD_PULSE;
        S_RD_PULSE: w_nxt = S_RD_WAIT;
        S_RD_WAIT: begin
          if (w_rd_edge)      w_nxt = S_CHECK;
          else if (w_tmo_hit) w_nxt = S_IDLE;
        end
        S_CHECK:    w_nxt = S_TX;
        S_TX: begin
          if (w_tx_go && r_tx_idx == TX_LAST)
            w_nxt = S_NEXT;
        end
        S_NEXT:     w_nxt = w_last_row ? S_IDLE : S_WR_SET;
        default:    w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_tmo         <= '0;
      r_tx_idx      <= '0;
      r_wt_q        <= 1'b0;
      r_rd_q        <= 1'b0;
      r_mask        <= '0;
      r_io_en       <= 1'b0;
      r_io_model    <= '0;
      r_wwl         <= '0;
      r_rwl         <= '0;
      r_wbl         <= '0;
      r_tx_en       <= 1'b0;
      r_tx_data     <= '0;
      r_busy        <= 1'b0;
      r_sweep_done  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt != S_IDLE);
      r_wt_q  <= wt_done;
      r_rd_q  <= rd_done;
      r_io_en <= 1'b0;
      r_tx_en <= 1'b0;
      if (!abort) begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_row         <= '0;
              r_sweep_done  <= 1'b0;
              r_timeout_err <= 1'b0;
              r_err_count   <= '0;
            end
          end
          S_WR_SET: begin
            r_io_model <= WR_MODEL;
            r_wwl      <= r_row;
            r_wbl      <= {8{w_pb}};
          end
          S_WR_PULSE: begin
            r_io_en <= 1'b1;
            r_tmo   <= '0;
          end
          S_WR_WAIT: begin
            r_tmo <= r_tmo + 20'd1;
            if (!w_wt_edge && w_tmo_hit)
              r_timeout_err <= 1'b1;
          end
          S_RD_SET: begin
            r_io_model <= RD_MODEL;
            r_rwl      <= r_row;
          end
          S_RD_PULSE: begin
            r_io_en <= 1'b1;
            r_tmo   <= '0;
          end
          S_RD_WAIT: begin
            r_tmo <= r_tmo + 20'd1;
            if (!w_rd_edge && w_tmo_hit)
              r_timeout_err <= 1'b1;
          end
          S_CHECK: begin
            r_mask      <= w_mask;
            r_tx_idx    <= '0;
            r_err_count <= w_sum[16] ? 16'hFFFF
                                     : w_sum[15:0];
          end
          S_TX: begin
            if (w_tx_go) begin
              r_tx_en   <= 1'b1;
              r_tx_data <= w_tx_byte;
              r_tx_idx  <= r_tx_idx + 2'd1;
            end
          end
          S_NEXT: begin
            if (w_last_row) r_sweep_done <= 1'b1;
            else            r_row <= r_row + 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign io_en       = r_io_en;
  assign io_model    = r_io_model;
  assign wwl_add     = r_wwl;
  assign rwl_dec_add = r_rwl;
  assign wbl_pattern = r_wbl;
  assign tx_en       = r_tx_en;
  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign sweep_done  = r_sweep_done;
  assign timeout_err = r_timeout_err;
  assign err_count   = r_err_count;

endmodule
